// File: rtl/cls_pkg.sv
// Shared PmodCLS protocol constants: command codes, ASCII bytes and parser state encodings.
// Used by both the receive-side parser and the command transmit side.
package cls_pkg;

    typedef enum logic [2:0] {
        CMD_CHAR       = 3'd0,
        CMD_CLEAR      = 3'd1,
        CMD_CURSOR     = 3'd2,
        CMD_ERASE_LINE = 3'd3,
        CMD_ERROR      = 3'd7
    } cmd_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ESC   = 2'd1,
        ST_PARAM = 2'd2
    } parse_state_e;

    localparam logic [7:0] ASCII_ESC    = 8'h1B;
    localparam logic [7:0] ASCII_LBRACK = 8'h5B;
    localparam logic [7:0] ASCII_CLEAR  = 8'h6A;
    localparam logic [7:0] ASCII_CURSOR = 8'h48;
    localparam logic [7:0] ASCII_ERASE  = 8'h4B;
    localparam logic [7:0] ASCII_SEMI   = 8'h3B;
    localparam logic [7:0] ASCII_ZERO   = 8'h30;
    localparam logic [7:0] ASCII_NINE   = 8'h39;
    localparam logic [7:0] ASCII_SPACE  = 8'h20;
    localparam logic [7:0] ASCII_TILDE  = 8'h7E;

    typedef struct packed {
        cmd_type_e   ctype;
        logic [7:0]  ch;
        logic [1:0]  row;
        logic [4:0]  col;
    } cls_cmd_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

    function automatic logic is_print(input logic [7:0] b);
        return (b >= ASCII_SPACE) && (b <= ASCII_TILDE);
    endfunction

    function automatic logic [7:0] clamp_u8(input logic [7:0] v, input logic [7:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/cls_param_acc.sv
// Two-slot decimal parameter accumulator: p[slot] = p[slot]*10 + digit, saturating at 255.
module cls_param_acc (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       digit_en,
    input  logic       slot,
    input  logic [3:0] digit,
    output logic [7:0] p0,
    output logic [7:0] p1
);

    logic [1:0][7:0] p_q, p_d;
    logic [11:0]     mac;

    always_comb begin
        p_d = p_q;
        mac = ({4'b0, p_q[slot]} * 12'd10) + {8'b0, digit};
        if (clear) begin
            p_d = '0;
        end else if (digit_en) begin
            p_d[slot] = (mac > 12'd255) ? 8'hFF : mac[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) p_q <= '0;
        else     p_q <= p_d;
    end

    assign p0 = p_q[0];
    assign p1 = p_q[1];

endmodule

// File: rtl/cls_escape_parser.sv
// PmodCLS receive decoder: printable bytes and "Esc [ params cmd" sequences -> one command each.
// Optional CLS_PARSE_ERRCNT_EN adds a saturating err_count output.
module cls_escape_parser
    import cls_pkg::*;
#(
    parameter int ROWS    = 2,
    parameter int COLS    = 16,
    parameter int MAX_SEQ = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] cmd_type,
    output logic [7:0] cmd_char,
    output logic [1:0] cmd_row,
    output logic [4:0] cmd_col
`ifdef CLS_PARSE_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam int         SEQ_W   = $clog2(MAX_SEQ + 1);
    localparam logic [7:0] ROW_MAX = 8'(ROWS - 1);
    localparam logic [7:0] COL_MAX = 8'(COLS - 1);

    parse_state_e     state_q, state_d;
    logic [SEQ_W-1:0] seq_q, seq_d, seq_next;
    logic [1:0]       idx_q, idx_d;
    cls_cmd_t         cmd_q, cmd_d;
    logic             cmd_valid_q, cmd_valid_d;

    logic             acc, at_limit, emit, acc_clear, digit_en;
    cmd_type_e        emit_type;
    logic [7:0]       emit_char, p0, p1, row8, col8;

    // Single holding register: accept a byte whenever the slot is empty or draining this cycle.
    assign rx_ready = !RST && (!cmd_valid_q || cmd_ready);
    assign acc      = rx_valid && rx_ready;

    cls_param_acc u_param_acc (
        .clk      (CLK),
        .rst      (RST),
        .clear    (acc_clear),
        .digit_en (digit_en),
        .slot     (idx_q[0]),
        .digit    (rx_data[3:0]),
        .p0       (p0),
        .p1       (p1)
    );

    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        idx_d       = idx_q;
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q && !cmd_ready;
        emit        = 1'b0;
        emit_type   = CMD_ERROR;
        emit_char   = 8'h00;
        acc_clear   = 1'b0;
        digit_en    = 1'b0;
        seq_next    = seq_q + SEQ_W'(1);
        at_limit    = (seq_next >= SEQ_W'(MAX_SEQ));
        row8        = clamp_u8(p0, ROW_MAX);
        col8        = clamp_u8(p1, COL_MAX);

        if (acc) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == ASCII_ESC) begin
                        state_d = ST_ESC;
                        seq_d   = '0;
                    end else if (is_print(rx_data)) begin
                        emit      = 1'b1;
                        emit_type = CMD_CHAR;
                        emit_char = rx_data;
                    end
                end
                ST_ESC: begin
                    seq_d = seq_next;
                    if (rx_data == ASCII_LBRACK) begin
                        acc_clear = 1'b1;
                        idx_d     = 2'd0;
                        emit      = at_limit;
                        state_d   = at_limit ? ST_IDLE : ST_PARAM;
                    end else if (rx_data == ASCII_ESC) begin
                        emit  = 1'b1;
                        seq_d = '0;
                    end else begin
                        emit    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_PARAM: begin
                    seq_d = seq_next;
                    // A terminator on the last allowed byte still completes the sequence.
                    if (is_digit(rx_data)) begin
                        digit_en = (idx_q != 2'd2);
                        if (at_limit) begin
                            emit    = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else if (rx_data == ASCII_SEMI) begin
                        if (idx_q == 2'd2 || at_limit) begin
                            emit    = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else if (rx_data == ASCII_CLEAR) begin
                        emit      = 1'b1;
                        emit_type = CMD_CLEAR;
                        state_d   = ST_IDLE;
                    end else if (rx_data == ASCII_CURSOR) begin
                        emit      = 1'b1;
                        emit_type = CMD_CURSOR;
                        state_d   = ST_IDLE;
                    end else if (rx_data == ASCII_ERASE) begin
                        emit      = 1'b1;
                        emit_type = CMD_ERASE_LINE;
                        state_d   = ST_IDLE;
                    end else if (rx_data == ASCII_ESC) begin
                        emit    = 1'b1;
                        state_d = ST_ESC;
                        seq_d   = '0;
                    end else begin
                        emit    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (emit) begin
            cmd_valid_d = 1'b1;
            cmd_d.ctype = emit_type;
            cmd_d.ch    = emit_char;
            cmd_d.row   = (emit_type == CMD_CURSOR) ? row8[1:0] : 2'd0;
            cmd_d.col   = (emit_type == CMD_CURSOR) ? col8[4:0] : 5'd0;
        end
    end

`ifdef CLS_PARSE_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (emit && emit_type == CMD_ERROR && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) err_cnt_q <= 8'h00;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            seq_q       <= '0;
            idx_q       <= 2'd0;
            cmd_q       <= '{ctype: CMD_CHAR, ch: 8'h00, row: 2'd0, col: 5'd0};
            cmd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            idx_q       <= idx_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_type  = cmd_q.ctype;
    assign cmd_char  = cmd_q.ch;
    assign cmd_row   = cmd_q.row;
    assign cmd_col   = cmd_q.col;

endmodule

// File: tb/tb_cls_escape_parser.sv
// Directed bench for cls_escape_parser: hand-computed command streams checked through one task.
module tb_cls_escape_parser;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic       cmd_valid;
    logic       cmd_ready = 1'b1;
    logic [2:0] cmd_type;
    logic [7:0] cmd_char;
    logic [1:0] cmd_row;
    logic [4:0] cmd_col;
`ifdef CLS_PARSE_ERRCNT_EN
    logic [7:0] err_count;
`endif

    localparam logic [2:0] T_CHAR = 3'd0, T_CLR = 3'd1, T_CUR = 3'd2, T_ERA = 3'd3, T_ERR = 3'd7;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [17:0] got_q[$];

    cls_escape_parser dut (
        .CLK       (CLK),
        .RST       (RST),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_char  (cmd_char),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col)
`ifdef CLS_PARSE_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 CLK = ~CLK;

    // Record every command at the point the consumer takes it.
    always @(negedge CLK) begin
        if (!RST && cmd_valid && cmd_ready) got_q.push_back({cmd_type, cmd_char, cmd_row, cmd_col});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        rx_data  = b;
        rx_valid = 1'b1;
        w = 0;
        @(negedge CLK);
        while (!rx_ready && w < 200) begin
            w++;
            @(negedge CLK);
        end
        if (!rx_ready) chk("rx_timeout", 32'(rx_ready), 32'd1);
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic settle();
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic exp_cmd(input string tag, input logic [2:0] t, input logic [7:0] c,
                           input logic [1:0] r, input logic [4:0] col);
        logic [17:0] g;
        g = (got_q.size() > 0) ? got_q.pop_front() : 18'h3FFFF;
        chk(tag, 32'(g), 32'({t, c, r, col}));
    endtask

    task automatic exp_none(input string tag);
        chk(tag, 32'(got_q.size()), 32'd0);
        got_q.delete();
    endtask

    initial begin
        int bad;
        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_fields", 32'({cmd_type, cmd_char, cmd_row, cmd_col}), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_rx_ready_after", 32'(rx_ready), 32'd1);
        @(posedge CLK); #1;

        // 1: Esc [ j -> CLEAR one cycle after the 'j' is taken
        send_byte(8'h1B);
        send_byte(8'h5B);
        chk("t1_pre", 32'(cmd_valid), 32'd0);
        send_byte(8'h6A);
        chk("t1_lat", 32'({cmd_valid, cmd_type}), 32'({1'b1, T_CLR}));
        settle();
        exp_cmd("t1_clear", T_CLR, 8'h00, 2'd0, 5'd0);
        exp_none("t1_none");

        // 2: cursor positioning and clamping
        send_byte(8'h1B); send_str("[1;5H");
        send_byte(8'h1B); send_str("[9;40H");
        send_byte(8'h1B); send_str("[H");
        settle();
        exp_cmd("t2_cur15", T_CUR, 8'h00, 2'd1, 5'd5);
        exp_cmd("t2_clamp", T_CUR, 8'h00, 2'd1, 5'd15);
        exp_cmd("t2_default", T_CUR, 8'h00, 2'd0, 5'd0);
        exp_none("t2_none");

        // 3: printable range and dropped control bytes
        send_byte(8'h41); send_byte(8'h0D); send_byte(8'h7A);
        send_byte(8'h20); send_byte(8'h7F); send_byte(8'h7E);
        settle();
        exp_cmd("t3_A", T_CHAR, 8'h41, 2'd0, 5'd0);
        exp_cmd("t3_z", T_CHAR, 8'h7A, 2'd0, 5'd0);
        exp_cmd("t3_sp", T_CHAR, 8'h20, 2'd0, 5'd0);
        exp_cmd("t3_tilde", T_CHAR, 8'h7E, 2'd0, 5'd0);
        exp_none("t3_none");

        // 4: back-pressure holds the command and stalls input
        cmd_ready = 1'b0;
        send_byte(8'h41);
        rx_data  = 8'h42;
        rx_valid = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge CLK);
            if (rx_ready !== 1'b0 || cmd_valid !== 1'b1 || cmd_char !== 8'h41 || cmd_type !== T_CHAR) bad++;
        end
        chk("t4_hold", 32'(bad), 32'd0);
        @(posedge CLK); #1;
        cmd_ready = 1'b1;
        send_byte(8'h42);
        settle();
        exp_cmd("t4_A", T_CHAR, 8'h41, 2'd0, 5'd0);
        exp_cmd("t4_B", T_CHAR, 8'h42, 2'd0, 5'd0);
        exp_none("t4_none");

        // 5: malformed sequences
        send_byte(8'h1B); send_str("[12"); send_byte(8'h1B); send_str("[j");
        settle();
        exp_cmd("t5_esc_err", T_ERR, 8'h00, 2'd0, 5'd0);
        exp_cmd("t5_esc_clr", T_CLR, 8'h00, 2'd0, 5'd0);
        exp_none("t5a_none");
        // 8th byte after Esc is a digit -> length abort, trailing 'H' is plain text
        send_byte(8'h1B); send_str("[999;1;2H");
        settle();
        exp_cmd("t5_long_err", T_ERR, 8'h00, 2'd0, 5'd0);
        exp_cmd("t5_long_H", T_CHAR, 8'h48, 2'd0, 5'd0);
        exp_none("t5b_none");
        send_byte(8'h1B); send_str("[1;2;3;");
        send_byte(8'h1B); send_str("[1x");
        send_byte(8'h1B); send_str("A");
        send_byte(8'h1B); send_byte(8'h1B); send_str("[j");
        settle();
        exp_cmd("t5_semi3", T_ERR, 8'h00, 2'd0, 5'd0);
        exp_cmd("t5_badbyte", T_ERR, 8'h00, 2'd0, 5'd0);
        exp_cmd("t5_esc_A", T_ERR, 8'h00, 2'd0, 5'd0);
        exp_cmd("t5_escesc", T_ERR, 8'h00, 2'd0, 5'd0);
        exp_cmd("t5_escesc_clr", T_CLR, 8'h00, 2'd0, 5'd0);
        exp_none("t5c_none");
        send_byte(8'h1B); send_str("[1234567j");
        send_byte(8'h1B); send_str("[1;2345H");
        settle();
        exp_cmd("t5_max_err", T_ERR, 8'h00, 2'd0, 5'd0);
        exp_cmd("t5_max_j", T_CHAR, 8'h6A, 2'd0, 5'd0);
        exp_cmd("t5_max_term", T_CUR, 8'h00, 2'd1, 5'd15);
        exp_none("t5d_none");

        // 6: reset discards a partial sequence and an unaccepted command
        send_byte(8'h1B); send_str("[1;");
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        send_byte(8'h1B); send_str("[K");
        settle();
        exp_cmd("t6_erase", T_ERA, 8'h00, 2'd0, 5'd0);
        exp_none("t6_none");
        cmd_ready = 1'b0;
        send_byte(8'h51);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("t6_rst_drop", 32'({cmd_valid, cmd_type, cmd_char}), 32'd0);
        RST = 1'b0;
        cmd_ready = 1'b1;
        settle();
        exp_none("t6_drop_none");

`ifdef CLS_PARSE_ERRCNT_EN
        chk("t6_errcnt_rst", 32'(err_count), 32'd0);
        repeat (3) begin send_byte(8'h1B); send_byte(8'h78); end
        settle();
        chk("t6_errcnt_3", 32'(err_count), 32'd3);
        repeat (297) begin send_byte(8'h1B); send_byte(8'h78); end
        settle();
        chk("t6_errcnt_sat", 32'(err_count), 32'd255);
        got_q.delete();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
